fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
Write-side controller of the asynchronous FIFO. It drives the write port of the distributed simple-dual-port RAM and owns the binary and Gray write pointers. It synchronises the read-domain Gray pointer into wr_clk and produces the full, water-level and optional almost-full flags. The matching read-side controller lives in rd_clk and exchanges Gray pointers with this block.

Parameters:
ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH; legal range 4-10.
DATA_WIDTH, 4, data width, passed straight through to the RAM; legal range 1-256.
ALMOST_FULL_NUM, 14, almost-full threshold in words; legal range 1 to 2**ADDR_WIDTH-1; used only when the optional feature is compiled in.

Ports:
wr_clk  in  1  write clock.
asyn_rst  in  1  reset: asynchronous, active-high.
wr_en  in  1  user write request.
wr_data  in  DATA_WIDTH  user write data.
rd_gray_ptr  in  ADDR_WIDTH+1  read pointer, Gray-coded, registered in the rd_clk domain.
ram_wr_en  out  1  RAM write enable.
ram_wr_addr  out  ADDR_WIDTH  RAM write address.
ram_wr_data  out  DATA_WIDTH  RAM write data.
wr_gray_ptr  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
wr_full  out  1  FIFO full, registered.
wr_water_level  out  ADDR_WIDTH+1  words stored, as seen from the write domain; registered.
almost_full  out  1  only when FIFO_WR_ALMOST_FULL_EN is defined.

Behaviour:
- Reset is asynchronous and active-high, and clears every register:
  - wr_ptr_bin, wr_gray_ptr and both synchroniser stages go to 0.
  - wr_full goes to 0, wr_water_level to 0, almost_full to 0.
- Write accept:
  - wr_accept = wr_en & ~wr_full.
  - ram_wr_en = wr_accept, combinational.
  - ram_wr_addr = wr_ptr_bin[ADDR_WIDTH-1:0], combinational.
  - ram_wr_data = wr_data, combinational.
  - The RAM captures the word on the same wr_clk edge.
- Pointer update:
  - wr_ptr_next = wr_ptr_bin + wr_accept, modulo 2**(ADDR_WIDTH+1); the MSB is the wrap bit.
  - wr_gray_next = wr_ptr_next ^ (wr_ptr_next >> 1).
  - wr_ptr_bin and wr_gray_ptr register the next values, so wr_gray_ptr changes by exactly one bit per accepted write.
- Read-pointer synchronisation:
  - Two flops in wr_clk: rd_gray_s1 then rd_gray_s2.
  - rd_bin_sync = Gray-to-binary of rd_gray_s2.
- Full flag:
  - Registered: wr_full <= (wr_gray_next == {~rd_gray_s2[AW:AW-1], rd_gray_s2[AW-2:0]}), where AW = ADDR_WIDTH.
  - Asserts on the edge of the write that stores the 2**ADDR_WIDTH-th word.
  - wr_en while full is ignored: no RAM write, no pointer change.
- Water level:
  - Registered: wr_water_level <= wr_ptr_next - rd_bin_sync, modulo 2**(ADDR_WIDTH+1).
  - Range 0 to 2**ADDR_WIDTH.
  - Conservative: it overstates occupancy by up to the synchronisation delay and never understates it.
- Latency:
  - Write to full or level update: 1 wr_clk.
  - Read-side pointer change to full deassert or level drop: 3 wr_clk (2 synchroniser stages + 1 flag register).
- Simultaneous write and synchronised-read arrival in one cycle: both are applied to the same flag computation; the level is unchanged if net zero.
- Wrap-around: the MSB toggles every 2**ADDR_WIDTH writes; the RAM address wraps from 2**ADDR_WIDTH-1 to 0 with no gap.
- Reset mid-operation: pointers return to 0 immediately, with no write on that edge. The read-side controller must be reset in the same event; this is a system requirement, not checked here.

Optional Feature:
- Macro name: FIFO_WR_ALMOST_FULL_EN.
- Defined:
  - Port almost_full exists.
  - Registered: almost_full <= (wr_ptr_next - rd_bin_sync) >= ALMOST_FULL_NUM, same timing as wr_water_level.
  - Reset value 0.
- Undefined: the port and its logic are absent, and ALMOST_FULL_NUM is unused.

Decomposition:
- Shared package fifo_pkg:
  - function bin2gray and function gray2bin, parameterised by width.
  - constant PTR_W = ADDR_WIDTH+1 (derived locally).
  - localparam DEPTH.
- One sub-module: fifo_gray_sync, a 2-stage synchroniser of width PTR_W with asynchronous reset, reused by the read-side controller for wr_gray_ptr.

Test Plan:
1. Reset, then 16 consecutive wr_en with ADDR_WIDTH=4 and rd_gray_ptr=0:
   - ram_wr_addr steps 0..15.
   - wr_full=1 one cycle after the 16th write.
   - wr_water_level=16.
   - wr_gray_ptr=5'b11000 (Gray of 16).
2. While full, hold wr_en=1 for 5 cycles: ram_wr_en=0 throughout; wr_gray_ptr and wr_water_level unchanged.
3. From full, set rd_gray_ptr to Gray(1)=5'b00001: wr_full falls exactly 3 wr_clk later, wr_water_level=15, and one further write is accepted.
4. Wrap test with a read-side model draining continuously, 40 writes total:
   - ram_wr_addr sequence wraps 15 to 0 twice.
   - wr_gray_ptr MSB toggles at write 16 and write 32.
   - Only one bit of wr_gray_ptr changes per write.
5. Assert asyn_rst mid-burst, asynchronous to wr_clk: all outputs are 0 before the next wr_clk edge, and the first post-reset write goes to address 0.
6. With FIFO_WR_ALMOST_FULL_EN defined and ALMOST_FULL_NUM=14, 14 writes with no reads: almost_full rises together with wr_water_level=14 and falls 3 cycles after the read pointer reaches 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and default geometry.
// Conversions work on any pointer width up to GRAY_W via zero extension.
package fifo_pkg;

    localparam int unsigned GRAY_W         = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEPTH          = 2 ** DEF_ADDR_WIDTH;

    typedef logic [GRAY_W-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int unsigned i = GRAY_W - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle of the async FIFO: user write port plus RAM write port.
interface fifo_wr_ctrl_if
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_full;
    logic [ADDR_WIDTH:0]   wr_water_level;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;

    // master: the user/RAM side; slave: the write controller
    modport master (
        output wr_en, wr_data,
        input  wr_full, wr_water_level, ram_wr_en, ram_wr_addr, ram_wr_data
    );

    modport slave (
        input  wr_en, wr_data,
        output wr_full, wr_water_level, ram_wr_en, ram_wr_addr, ram_wr_data
    );
endinterface

// File: rtl/fifo_gray_sync.sv
// Two-stage synchroniser for a Gray-coded pointer crossing into clk.
module fifo_gray_sync #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             asyn_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] s1;

    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: write pointers, full and water level.
// Optional almost_full output when FIFO_WR_ALMOST_FULL_EN is defined.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = 4,
    parameter int unsigned ALMOST_FULL_NUM = 14
) (
    input  logic                wr_clk,
    input  logic                asyn_rst,
    fifo_wr_ctrl_if.slave       wif,
    input  logic [ADDR_WIDTH:0] rd_gray_ptr,
    output logic [ADDR_WIDTH:0] wr_gray_ptr
`ifdef FIFO_WR_ALMOST_FULL_EN
    ,
    output logic                almost_full
`endif
);
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned AW    = ADDR_WIDTH;

    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t       wr_ptr_bin;
    ptr_t       wr_ptr_next;
    ptr_t       wr_gray_next;
    ptr_t       rd_gray_s2;
    ptr_t       rd_bin_sync;
    ptr_t       full_match;
    ptr_t       level_next;
    ptr_t       level_q;
    logic       wr_full_q;
    logic       wr_accept;
    gray_word_t wr_gray_wide;
    gray_word_t rd_bin_wide;
    logic       unused_wide_hi;

    fifo_gray_sync #(.WIDTH(PTR_W)) u_rd_sync (
        .clk      (wr_clk),
        .asyn_rst (asyn_rst),
        .d        (rd_gray_ptr),
        .q        (rd_gray_s2)
    );

    // Reset also masks the RAM strobe so a mid-burst reset never writes.
    always_comb begin
        wr_accept    = wif.wr_en & ~wr_full_q & ~asyn_rst;
        wr_ptr_next  = wr_ptr_bin + PTR_W'(wr_accept);
        wr_gray_wide = bin2gray(GRAY_W'(wr_ptr_next));
        wr_gray_next = wr_gray_wide[PTR_W-1:0];
        rd_bin_wide  = gray2bin(GRAY_W'(rd_gray_s2));
        rd_bin_sync  = rd_bin_wide[PTR_W-1:0];
        full_match   = {~rd_gray_s2[AW:AW-1], rd_gray_s2[AW-2:0]};
        level_next   = wr_ptr_next - rd_bin_sync;
    end

    assign unused_wide_hi = ^{wr_gray_wide[GRAY_W-1:PTR_W], rd_bin_wide[GRAY_W-1:PTR_W]};

    assign wif.ram_wr_en      = wr_accept;
    assign wif.ram_wr_addr    = wr_ptr_bin[AW-1:0];
    assign wif.ram_wr_data    = DATA_WIDTH'(wif.wr_data);
    assign wif.wr_full        = wr_full_q;
    assign wif.wr_water_level = level_q;

    always_ff @(posedge wr_clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            wr_ptr_bin  <= '0;
            wr_gray_ptr <= '0;
            wr_full_q   <= 1'b0;
            level_q     <= '0;
        end else begin
            wr_ptr_bin  <= wr_ptr_next;
            wr_gray_ptr <= wr_gray_next;
            wr_full_q   <= (wr_gray_next == full_match);
            level_q     <= level_next;
        end
    end

`ifdef FIFO_WR_ALMOST_FULL_EN
    always_ff @(posedge wr_clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (level_next >= PTR_W'(ALMOST_FULL_NUM));
        end
    end
`else
    localparam int unsigned unused_almost_full_num = ALMOST_FULL_NUM;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl against a word-count reference model.
module tb_fifo_wr_ctrl;
    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 4;
    localparam int unsigned AFN = 14;

    logic          wr_clk = 1'b0;
    logic          asyn_rst;
    logic [AW:0]   rd_gray_ptr;
    logic [AW:0]   wr_gray_ptr;
`ifdef FIFO_WR_ALMOST_FULL_EN
    logic          almost_full;
`endif

    fifo_wr_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wif ();

    fifo_wr_ctrl #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .ALMOST_FULL_NUM (AFN)
    ) dut (
        .wr_clk      (wr_clk),
        .asyn_rst    (asyn_rst),
        .wif         (wif),
        .rd_gray_ptr (rd_gray_ptr),
        .wr_gray_ptr (wr_gray_ptr)
`ifdef FIFO_WR_ALMOST_FULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: counts of words written / read, read count seen late.
    int m_wr;
    int m_rd;
    int m_level;
    bit m_full;
    bit m_af;
    int hist[$];

    function automatic int g(input int n);
        return n ^ (n >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int n);
        m_rd        = n;
        rd_gray_ptr = 5'(g(n % 32));
    endtask

    task automatic model_clear();
        m_wr    = 0;
        m_level = 0;
        m_full  = 1'b0;
        m_af    = 1'b0;
        hist.delete();
    endtask

    task automatic do_reset();
        asyn_rst   = 1'b1;
        wif.wr_en  = 1'b0;
        set_rd(0);
        repeat (2) @(posedge wr_clk);
        #1;
        asyn_rst = 1'b0;
        model_clear();
    endtask

    // One wr_clk edge: advance the model, then compare every output.
    task automatic tick();
        int seen;
        bit acc;
        acc  = wif.wr_en && !m_full;
        seen = (hist.size() >= 2) ? hist[hist.size()-2] : 0;
        hist.push_back(m_rd);
        if (hist.size() > 4) void'(hist.pop_front());
        m_wr    = m_wr + int'(acc);
        m_level = m_wr - seen;
        m_full  = (m_level == 16);
        m_af    = (m_level >= int'(AFN));
        @(posedge wr_clk);
        #1;
        chk("ram_wr_addr", 32'(wif.ram_wr_addr), m_wr % 16);
        chk("wr_gray_ptr", 32'(wr_gray_ptr), g(m_wr % 32));
        chk("wr_full", 32'(wif.wr_full), 32'(m_full));
        chk("wr_water_level", 32'(wif.wr_water_level), m_level);
        chk("ram_wr_en", 32'(wif.ram_wr_en), 32'(wif.wr_en && !m_full));
        if (wif.ram_wr_en) chk("ram_wr_data", 32'(wif.ram_wr_data), 32'(wif.wr_data));
`ifdef FIFO_WR_ALMOST_FULL_EN
        chk("almost_full", 32'(almost_full), 32'(m_af));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, finish required");
        $fatal(1);
    end

    initial begin
        int edges;
        int wraps;
        int toggles[$];
        logic [AW:0]   prev_gray;
        logic [AW-1:0] prev_addr;
        int prev_wr;

        asyn_rst     = 1'b1;
        wif.wr_en    = 1'b0;
        wif.wr_data  = '0;
        set_rd(0);
        model_clear();
        #1;
        chk("rst_gray", 32'(wr_gray_ptr), 0);
        chk("rst_full", 32'(wif.wr_full), 0);
        chk("rst_level", 32'(wif.wr_water_level), 0);
        chk("rst_addr", 32'(wif.ram_wr_addr), 0);
        chk("rst_ram_wr_en", 32'(wif.ram_wr_en), 0);
        do_reset();

        // 16 writes with no reads fill the FIFO
        for (int i = 0; i < 16; i++) begin
            wif.wr_en   = 1'b1;
            wif.wr_data = 4'($urandom);
            #0;
            chk("fill_addr", 32'(wif.ram_wr_addr), i);
            tick();
        end
        chk("fill_full", 32'(wif.wr_full), 1);
        chk("fill_level", 32'(wif.wr_water_level), 16);
        chk("fill_gray", 32'(wr_gray_ptr), 32'h18);

        // writes while full are ignored
        for (int i = 0; i < 5; i++) begin
            wif.wr_data = 4'($urandom);
            #0;
            chk("full_no_write", 32'(wif.ram_wr_en), 0);
            tick();
            chk("full_gray_hold", 32'(wr_gray_ptr), 32'h18);
            chk("full_level_hold", 32'(wif.wr_water_level), 16);
        end

        // one read releases full three edges later
        wif.wr_en = 1'b0;
        set_rd(1);
        edges = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            edges++;
            if (!wif.wr_full) break;
        end
        chk("full_fall_latency", edges, 3);
        chk("full_fall_level", 32'(wif.wr_water_level), 15);
        wif.wr_en   = 1'b1;
        wif.wr_data = 4'($urandom);
        tick();
        chk("refill_gray", 32'(wr_gray_ptr), g(17));
        chk("refill_full", 32'(wif.wr_full), 1);
        wif.wr_en = 1'b0;

        // random writes against a draining reader, 40 writes total
        do_reset();
        wraps = 0;
        toggles.delete();
        for (int cyc = 0; cyc < 400 && m_wr < 40; cyc++) begin
            wif.wr_en   = ($urandom_range(0, 3) != 0) && (m_wr < 40);
            wif.wr_data = 4'($urandom);
            if (m_rd < m_wr && $urandom_range(0, 1) == 1) set_rd(m_rd + 1);
            prev_gray = wr_gray_ptr;
            prev_addr = wif.ram_wr_addr;
            prev_wr   = m_wr;
            tick();
            chk("gray_one_bit", $countones(prev_gray ^ wr_gray_ptr), m_wr - prev_wr);
            if (m_wr != prev_wr) begin
                if (prev_gray[AW] != wr_gray_ptr[AW]) toggles.push_back(m_wr);
                if (prev_addr == 4'd15 && wif.ram_wr_addr == 4'd0) wraps++;
            end
        end
        chk("wrap_writes_done", m_wr, 40);
        chk("wrap_count", wraps, 2);
        chk("msb_toggle_count", toggles.size(), 2);
        if (toggles.size() == 2) begin
            chk("msb_toggle_first", toggles[0], 16);
            chk("msb_toggle_second", toggles[1], 32);
        end

        // asynchronous reset in the middle of a burst
        do_reset();
        wif.wr_en = 1'b1;
        repeat (3) tick();
        #3;
        asyn_rst = 1'b1;
        #1;
        chk("arst_ram_wr_en", 32'(wif.ram_wr_en), 0);
        chk("arst_addr", 32'(wif.ram_wr_addr), 0);
        chk("arst_gray", 32'(wr_gray_ptr), 0);
        chk("arst_full", 32'(wif.wr_full), 0);
        chk("arst_level", 32'(wif.wr_water_level), 0);
`ifdef FIFO_WR_ALMOST_FULL_EN
        chk("arst_af", 32'(almost_full), 0);
`endif
        #2;
        asyn_rst = 1'b0;
        model_clear();
        #1;
        chk("post_rst_addr", 32'(wif.ram_wr_addr), 0);
        chk("post_rst_ram_wr_en", 32'(wif.ram_wr_en), 1);
        tick();
        chk("post_rst_gray", 32'(wr_gray_ptr), 1);
        wif.wr_en = 1'b0;

`ifdef FIFO_WR_ALMOST_FULL_EN
        // almost_full threshold and its release after one read
        do_reset();
        wif.wr_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            wif.wr_data = 4'($urandom);
            tick();
        end
        chk("af_rise", 32'(almost_full), 1);
        chk("af_level", 32'(wif.wr_water_level), 14);
        wif.wr_en = 1'b0;
        set_rd(1);
        edges = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            edges++;
            if (!almost_full) break;
        end
        chk("af_fall_latency", edges, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
